// File: rtl/sim_verdict_monitor.sv
// sim_verdict_monitor: reduces checker pass/fail/done/report events to a sticky verdict with a watchdog.
module sim_verdict_monitor #(
   parameter int TIMEOUT_CYCLES = 64000,
   parameter int MIN_PASSES     = 1,
   parameter int CNT_W          = 16
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             check_pass,
   input  logic             check_fail,
   input  logic [31:0]      fail_code,
   input  logic             done,
   input  logic             report_valid,
   input  logic [31:0]      report_word,
   output logic             sim_success,
   output logic             sim_failure,
   output logic [31:0]      sim_report,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic             running
);
   localparam logic [1:0] RUN = 2'd0, PASSED = 2'd1, FAILED = 2'd2;
   localparam int WD_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W:0] MIN_P = (CNT_W+1)'(MIN_PASSES);
   logic [1:0] state;
   logic [WD_W-1:0] wd;
   logic [CNT_W-1:0] p_nxt, f_nxt;
   logic in_run, wd_exp, short;
   assign in_run = state == RUN;
   assign p_nxt = pass_count + CNT_W'(check_pass && pass_count != CNT_MAX);
   assign f_nxt = fail_count + CNT_W'(check_fail && fail_count != CNT_MAX);
   assign wd_exp = TIMEOUT_CYCLES != 0 && wd == WD_W'(TIMEOUT_CYCLES - 1);
   // the same-cycle pass strobe counts towards the minimum
   assign short = {1'b0, p_nxt} < MIN_P;
   assign sim_success = state == PASSED;
   assign sim_failure = state == FAILED;
   assign running = in_run;
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         wd         <= '0;
         pass_count <= '0;
         fail_count <= '0;
         sim_report <= '0;
      end else begin
         pass_count <= p_nxt;
         fail_count <= f_nxt;
         if (in_run) begin
            wd <= wd + 1'b1;
            if (check_fail) begin
               state      <= FAILED;
               sim_report <= fail_code;
            end else if (wd_exp) begin
               state      <= FAILED;
               sim_report <= 32'hDEAD_0001;
            end else if (done && short) begin
               state      <= FAILED;
               sim_report <= 32'hDEAD_0002;
            end else if (done) begin
               state <= fail_count != '0 ? FAILED : PASSED;
            end else if (report_valid) begin
               sim_report <= report_word;
            end
         end
      end
   end
endmodule
